// File: rtl/opcode_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : opcode_alu_seq
// Description : Multi-cycle opcode ALU on unsigned WIDTH-bit operands.
//               op 0 add, op 1 subtract (one-cycle latency); op 2 multiply
//               (shift-add), op 3 quotient, op 4 remainder (restoring
//               divide), each taking WIDTH iterations. Any other op returns
//               the opcode itself. Divide/modulo by zero raises dz.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               in_valid/in_ready   - operation handshake (op, a, b)
//               out_valid/out_ready - result handshake (d, dz)
//               busy                - iterating on multiply/divide
// Revision    : 1.0 - initial release
// ============================================================================
module opcode_alu_seq #(
  parameter int WIDTH = 12,
  parameter int OUT_W = 32,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] d,
  output logic             dz,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [OP_W-1:0]  C_OP_ADD   = OP_W'(0);
  localparam logic [OP_W-1:0]  C_OP_SUB   = OP_W'(1);
  localparam logic [OP_W-1:0]  C_OP_MUL   = OP_W'(2);
  localparam logic [OP_W-1:0]  C_OP_DIV   = OP_W'(3);
  localparam logic [OP_W-1:0]  C_OP_MOD   = OP_W'(4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [OP_W-1:0]    r_op;
  logic [WIDTH-1:0]   r_b;
  logic [OUT_W-1:0]   r_acc;     // multiply partial product
  logic [OUT_W-1:0]   r_mcand;   // multiplicand, shifted left each step
  logic [WIDTH-1:0]   r_mplier;  // multiplier, shifted right each step
  logic [WIDTH-1:0]   r_rem;     // divide partial remainder
  logic [WIDTH-1:0]   r_quo;     // dividend bits shift out, quotient bits shift in
  logic [OUT_W-1:0]   r_d;
  logic               r_dz;

  logic               w_multi;
  logic [OUT_W-1:0]   w_a_ext, w_b_ext, w_quick;
  logic [OUT_W-1:0]   w_acc_step;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_step, w_quo_step;
  logic [OUT_W-1:0]   w_final;

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_BUSY);
  assign d         = r_d;
  assign dz        = r_dz;

  assign w_multi = (op == C_OP_MUL) || (op == C_OP_DIV) || (op == C_OP_MOD);
  assign w_a_ext = {{(OUT_W-WIDTH){1'b0}}, a};
  assign w_b_ext = {{(OUT_W-WIDTH){1'b0}}, b};

  always_comb begin
    w_quick = {{(OUT_W-OP_W){1'b0}}, op};
    if (op == C_OP_ADD)      w_quick = w_a_ext + w_b_ext;
    else if (op == C_OP_SUB) w_quick = w_a_ext - w_b_ext;
  end

  // One shift-add multiply step and one restoring divide step run in
  // parallel every BUSY cycle; r_op picks which result is kept.
  assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_b});
  // The remainder stays below the divisor, so the difference fits WIDTH bits.
  // With a zero divisor every step subtracts nothing: the quotient fills
  // with ones and the remainder ends up equal to the dividend.
  assign w_rem_step = w_ge ? WIDTH'(w_rem_sh - {1'b0, r_b}) : w_rem_sh[WIDTH-1:0];
  assign w_quo_step = {r_quo[WIDTH-2:0], w_ge};

  always_comb begin
    w_final = {{(OUT_W-WIDTH){1'b0}}, w_rem_step};
    if (r_op == C_OP_MUL)      w_final = w_acc_step;
    else if (r_op == C_OP_DIV) w_final = {{(OUT_W-WIDTH){1'b0}}, w_quo_step};
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_next = w_multi ? S_BUSY : S_DONE;
      S_BUSY:  if (r_cnt == C_CNT_ONE) w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_d      <= '0;
      r_dz     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op     <= op;
            r_b      <= b;
            r_acc    <= '0;
            r_mcand  <= w_a_ext;
            r_mplier <= b;
            r_rem    <= '0;
            r_quo    <= a;
            r_cnt    <= C_CNT_INIT;
            r_dz     <= ((op == C_OP_DIV) || (op == C_OP_MOD)) && (b == '0);
            if (!w_multi) r_d <= w_quick;
          end
        end
        S_BUSY: begin
          r_acc    <= w_acc_step;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_rem    <= w_rem_step;
          r_quo    <= w_quo_step;
          r_cnt    <= r_cnt - C_CNT_ONE;
          if (r_cnt == C_CNT_ONE) r_d <= w_final;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_opcode_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_opcode_alu_seq
// Description : Directed self-checking bench for opcode_alu_seq with
//               WIDTH=12, OUT_W=32, expected values worked out by hand.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_opcode_alu_seq;

  localparam int WIDTH = 12;
  localparam int OUT_W = 32;
  localparam int OP_W  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [OP_W-1:0]  op = '0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OUT_W-1:0] d;
  logic             dz;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  opcode_alu_seq #(.WIDTH(WIDTH), .OUT_W(OUT_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .dz(dz), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one operation at a negedge, scramble the inputs after accept, then
  // measure latency (in negedges after the accept edge) and busy cycles.
  task automatic run_op(input string tag, input logic [OP_W-1:0] t_op,
                        input logic [WIDTH-1:0] t_a, input logic [WIDTH-1:0] t_b,
                        input logic [31:0] exp_d, input logic exp_dz, input int exp_lat);
    int lat;
    int busy_cnt;
    lat = 0;
    busy_cnt = 0;
    @(negedge clk);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    op = t_op; a = t_a; b = t_b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = ~t_op; a = ~t_a; b = ~t_b;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
      if (busy) busy_cnt++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_lat - 1);
    check({tag, "_d"}, d, exp_d);
    check({tag, "_dz"}, {31'd0, dz}, {31'd0, exp_dz});
    @(posedge clk);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_d", d, 32'd0);
    check("rst_dz", {31'd0, dz}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Add / subtract
    run_op("add_max", 4'd0, 12'd4095, 12'd4095, 32'd8190, 1'b0, 1);
    run_op("sub_wrap", 4'd1, 12'd3, 12'd5, 32'hFFFF_FFFE, 1'b0, 1);
    // Multiply
    run_op("mul_max", 4'd2, 12'd4095, 12'd4095, 32'd16769025, 1'b0, 13);
    run_op("mul_small", 4'd2, 12'd7, 12'd6, 32'd42, 1'b0, 13);
    // Divide / modulo
    run_op("div", 4'd3, 12'd100, 12'd7, 32'd14, 1'b0, 13);
    run_op("mod", 4'd4, 12'd100, 12'd7, 32'd2, 1'b0, 13);
    run_op("div_by1", 4'd3, 12'd4095, 12'd1, 32'd4095, 1'b0, 13);
    // Divide by zero and default opcode
    run_op("div0", 4'd3, 12'd55, 12'd0, 32'h0000_0FFF, 1'b1, 13);
    run_op("mod0", 4'd4, 12'd55, 12'd0, 32'd55, 1'b1, 13);
    run_op("op9", 4'd9, 12'd55, 12'd0, 32'd9, 1'b0, 1);

    // Backpressure: result held, second request ignored
    @(negedge clk);
    out_ready = 1'b0;
    op = 4'd0; a = 12'd1; b = 12'd2; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_d", d, 32'd3);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      if (n == 2) begin
        op = 4'd2; a = 12'd7; b = 12'd7; in_valid = 1'b1;
      end
      if (n == 5) in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_release_busy", {31'd0, busy}, 32'd0);
    check("bp_d_held", d, 32'd3);

    // Reset in the middle of a multiply
    op = 4'd2; a = 12'd100; b = 12'd100; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 6; n++) @(negedge clk);
    check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_d", d, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_post_in_ready", {31'd0, in_ready}, 32'd1);
    run_op("add_after_rst", 4'd0, 12'd2, 12'd2, 32'd4, 1'b0, 1);
    // A multiply after the abort must start from cleared accumulators
    run_op("mul_after_rst", 4'd2, 12'd3, 12'd5, 32'd15, 1'b0, 13);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute guard so the run always ends even if the DUT wedges.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
